// File: rtl/pipe_stage_skid_pkg.sv
// Shared constants for the pipeline stage registers: bubble values,
// per-boundary payload widths and the occupancy state encoding.
package pipe_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] INSTR_NOP        = 32'h0;

    // Payload widths per stage boundary (D/E: check + WD1 + WD2 + EXTResult)
    localparam int F2D_PAYLOAD_W = 32;
    localparam int D2E_PAYLOAD_W = 97;
    localparam int E2M_PAYLOAD_W = 97;
    localparam int M2W_PAYLOAD_W = 65;

    // Stage occupancy: nothing held, main only, main plus skid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying instruction, PC and payload.
// The producer uses the master modport, the consumer the slave modport.
interface pipe_stage_skid_if #(
    parameter int INSTR_W   = 32,
    parameter int PAYLOAD_W = 97
);
    logic                 valid;
    logic                 ready;
    logic [INSTR_W-1:0]   instr;
    logic [31:0]          pc;
    logic [PAYLOAD_W-1:0] payload;

    modport master (output valid, instr, pc, payload, input ready);
    modport slave  (input valid, instr, pc, payload, output ready);
endinterface

// File: rtl/pipe_stage_skid_entry_reg.sv
// One stage entry: valid bit plus fields. Clearing writes bubble values
// so the fields are never stale when the entry is invalid.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int          INSTR_W   = 32,
    parameter int          PAYLOAD_W = D2E_PAYLOAD_W,
    parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 load,
    input  logic [INSTR_W-1:0]   d_instr,
    input  logic [31:0]          d_pc,
    input  logic [PAYLOAD_W-1:0] d_payload,
    output logic                 q_valid,
    output logic [INSTR_W-1:0]   q_instr,
    output logic [31:0]          q_pc,
    output logic [PAYLOAD_W-1:0] q_payload
);

    // Clear to bubble has priority over load; otherwise hold
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q_valid   <= 1'b0;
            q_instr   <= INSTR_W'(INSTR_NOP);
            q_pc      <= PC_RESET;
            q_payload <= '0;
        end else if (load) begin
            q_valid   <= 1'b1;
            q_instr   <= d_instr;
            q_pc      <= d_pc;
            q_payload <= d_payload;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer.
// Outputs come straight from the main entry; in_ready is registered
// (low only while the skid entry is occupied), so out_ready never
// reaches in_ready combinationally.
// Optional build macro PIPE_STAGE_PERF_EN adds stall/bubble counters.
//
//   state    | meaning
//   ST_EMPTY | no entry held, out_valid=0
//   ST_ONE   | main valid, skid empty
//   ST_TWO   | main and skid valid, in_ready=0
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int          PAYLOAD_W = D2E_PAYLOAD_W,
    parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
    parameter int          INSTR_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    pipe_stage_skid_if.slave   up,
    pipe_stage_skid_if.master  dn
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        bubble_cnt
`endif
);

    stage_state_e         state_q;
    stage_state_e         state_d;
    logic                 in_ready_q;

    logic                 accept;
    logic                 drain;
    logic                 main_load;
    logic                 main_clr;
    logic                 skid_load;
    logic                 skid_clr;

    logic                 main_valid;
    logic [INSTR_W-1:0]   main_instr;
    logic [31:0]          main_pc;
    logic [PAYLOAD_W-1:0] main_payload;
    logic                 skid_valid;
    logic [INSTR_W-1:0]   skid_instr;
    logic [31:0]          skid_pc;
    logic [PAYLOAD_W-1:0] skid_payload;

    logic [INSTR_W-1:0]   main_d_instr;
    logic [31:0]          main_d_pc;
    logic [PAYLOAD_W-1:0] main_d_payload;
    logic                 sel_skid;

    assign accept = up.valid & in_ready_q;
    assign drain  = main_valid & dn.ready;

    // Next occupancy and entry load/clear strobes; flush empties both
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_clr  = flush;
        skid_load = 1'b0;
        skid_clr  = flush;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_load = 1'b1;
                    state_d   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (drain && accept) begin
                    main_load = 1'b1;
                end else if (drain) begin
                    main_clr  = 1'b1;
                    state_d   = ST_EMPTY;
                end else if (accept) begin
                    skid_load = 1'b1;
                    state_d   = ST_TWO;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    main_load = 1'b1;
                    skid_clr  = 1'b1;
                    state_d   = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    // Occupancy register with registered in_ready
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    // Main reloads from skid when skid holds the older entry
    assign sel_skid       = (state_q == ST_TWO);
    assign main_d_instr   = sel_skid ? skid_instr   : up.instr;
    assign main_d_pc      = sel_skid ? skid_pc      : up.pc;
    assign main_d_payload = sel_skid ? skid_payload : up.payload;

    pipe_entry_reg #(
        .INSTR_W  (INSTR_W),
        .PAYLOAD_W(PAYLOAD_W),
        .PC_RESET (PC_RESET)
    ) u_main (
        .clk      (clk),
        .reset    (reset),
        .clear    (main_clr),
        .load     (main_load),
        .d_instr  (main_d_instr),
        .d_pc     (main_d_pc),
        .d_payload(main_d_payload),
        .q_valid  (main_valid),
        .q_instr  (main_instr),
        .q_pc     (main_pc),
        .q_payload(main_payload)
    );

    pipe_entry_reg #(
        .INSTR_W  (INSTR_W),
        .PAYLOAD_W(PAYLOAD_W),
        .PC_RESET (PC_RESET)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .clear    (skid_clr),
        .load     (skid_load),
        .d_instr  (up.instr),
        .d_pc     (up.pc),
        .d_payload(up.payload),
        .q_valid  (skid_valid),
        .q_instr  (skid_instr),
        .q_pc     (skid_pc),
        .q_payload(skid_payload)
    );

    assign up.ready   = in_ready_q;
    assign dn.valid   = main_valid;
    assign dn.instr   = main_instr;
    assign dn.pc      = main_pc;
    assign dn.payload = main_payload;

`ifdef PIPE_STAGE_PERF_EN
    // Stall and bubble cycle counters; only reset clears them
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (main_valid && !dn.ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (!main_valid) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

    // skid_valid mirrors state_q == ST_TWO; kept for visibility in waves
    logic unused_skid_valid;
    assign unused_skid_valid = skid_valid;

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Generic pipeline stage register, the successor to the fixed D→E stage register. It carries instruction, PC and a parametrised payload between two pipeline stages, using a valid/ready handshake and a 2-entry skid buffer so that a downstream stall does not combinationally stall upstream. Flush inserts a bubble: instr=0 (nop), pc=PC_RESET, payload=0. One instance per stage boundary (F/D, D/E, E/M, M/W).

Parameters:
PAYLOAD_W, 97, width of the stage-specific payload (e.g. check + WD1 + WD2 + EXTResult = 1+32+32+32).
PC_RESET, 32'h0000_3000, PC value carried by reset and bubble entries.
INSTR_W, 32, instruction width.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
flush  input  1  synchronous clear; empties both entries.
in_valid  input  1  upstream presents a valid entry.
in_ready  output  1  stage can accept; registered, equals !skid_valid.
in_instr  input  INSTR_W  upstream instruction.
in_pc  input  32  upstream PC.
in_payload  input  PAYLOAD_W  upstream payload.
out_valid  output  1  main entry valid.
out_ready  input  1  downstream accepts the main entry this cycle.
out_instr  output  INSTR_W  main entry instruction; 0 when !out_valid.
out_pc  output  32  main entry PC; PC_RESET when !out_valid.
out_payload  output  PAYLOAD_W  main entry payload; 0 when !out_valid.

Behaviour:
- Storage: main entry (main_valid, fields) and skid entry (skid_valid, fields). out_* come directly from main registers.
- States: EMPTY (!main_valid), ONE (main_valid & !skid_valid), TWO (main_valid & skid_valid). TWO implies in_ready=0.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- EMPTY: accept → ONE, input loaded into main.
- ONE:
  - drain & accept → ONE, main reloaded.
  - drain only → EMPTY.
  - accept only → TWO, input goes to skid.
  - neither → hold.
- TWO: drain → ONE, skid moves to main, skid cleared. No drain → hold. Input is ignored because in_ready=0.
- Ordering is strictly FIFO. Every entry appears on out_* exactly once, in arrival order, for at least one cycle.
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput is 1 entry/cycle while out_ready=1.
- Invalid entries are always written with bubble values: instr=0, pc=PC_RESET, payload=0. Outputs are therefore bubble values whenever out_valid=0.
- reset: both entries invalid with bubble values; in_ready=1 the next cycle; out_valid=0, out_instr=0, out_pc=PC_RESET, out_payload=0.
- flush (reset has priority over flush): same effect as reset on the next edge. A same-cycle accept is discarded and a same-cycle drain is still legal downstream. Flush during TWO loses both entries.
- Upstream must hold in_* stable while in_valid & !in_ready. in_valid may drop without an accept (no AXI-style obligation).
- No combinational path from out_ready to in_ready.

Optional Feature:
PIPE_STAGE_PERF_EN.
- Defined: adds output ports stall_cnt[31:0] and bubble_cnt[31:0].
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - bubble_cnt increments each cycle with !out_valid & !reset.
  - Both wrap modulo 2^32, are cleared by reset only (not by flush), and count one cycle after the condition.
- Undefined: ports and counters are absent. Handshake behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds: PC_RESET_DEFAULT=32'h0000_3000, INSTR_NOP=32'h0, and the per-stage payload width constants (D2E_PAYLOAD_W=97 etc.).
- One natural sub-module, pipe_entry_reg: a single valid+fields register with load/clear-to-bubble, instantiated twice (main, skid).

Test Plan:
- Reset mid-stream in TWO → next cycle out_valid=0, out_pc=32'h3000, out_instr=0, in_ready=1.
- Streaming with out_ready=1, inputs pc 0x3000,0x3004,0x3008 on consecutive cycles → outputs appear 1 cycle later in order, in_ready stays 1.
- Back-pressure: load A (pc 0x3010) then B (pc 0x3014) with out_ready=0 → in_ready=0. Deassert out_ready for 3 cycles then assert → A then B out, C accepted only after skid empties.
- Flush in TWO with in_valid=1 carrying pc 0x3020 → next cycle out_valid=0, out_pc=0x3000. Entry 0x3020 never appears.
- Simultaneous drain and accept in ONE (main pc 0x3040, input 0x3044) → next cycle main=0x3044, skid empty.
- PIPE_STAGE_PERF_EN: 5 cycles out_valid=1/out_ready=0, then 3 idle cycles → stall_cnt=5, bubble_cnt=3. A flush leaves the counts unchanged.
